// File: rtl/mem_stage_if.sv
// EX-to-MEM bundle, pipeline control, write-back/branch results and the debug read port of mem_stage.
// The stage takes the slave side; whoever drives EX and consumes WB takes the master side.
interface mem_stage_if #(
    parameter int NB_DATA = 32,
    parameter int NB_PC   = 32,
    parameter int NB_REG  = 5,
    parameter int NB_ADDR = 8
);
    logic               i_enable;
    logic               i_flush;
    logic               i_EX_reg_write;
    logic               i_EX_mem_to_reg;
    logic               i_EX_mem_read;
    logic               i_EX_mem_write;
    logic               i_EX_branch;
    logic               i_EX_zero;
    logic               i_EX_byte_en;
    logic               i_EX_halfword_en;
    logic               i_EX_word_en;
    logic               i_EX_r31_ctrl;
    logic               i_EX_signed;
    logic [NB_PC-1:0]   i_EX_branch_addr;
    logic [NB_DATA-1:0] i_EX_alu_result;
    logic [NB_DATA-1:0] i_EX_data_b;
    logic [NB_REG-1:0]  i_EX_selected_reg;
    logic [NB_PC-1:0]   i_EX_pc;
    logic               i_du_req;
    logic [NB_ADDR-1:0] i_du_addr;
    logic               o_MEM_pc_src;
    logic [NB_PC-1:0]   o_MEM_branch_addr;
    logic               o_WB_reg_write;
    logic [NB_REG-1:0]  o_WB_selected_reg;
    logic [NB_DATA-1:0] o_WB_write_data;
    logic               o_misaligned;
    logic               o_du_ack;
    logic [NB_DATA-1:0] o_du_data;

    modport slave (
        input  i_enable, i_flush,
        input  i_EX_reg_write, i_EX_mem_to_reg, i_EX_mem_read, i_EX_mem_write,
        input  i_EX_branch, i_EX_zero, i_EX_byte_en, i_EX_halfword_en, i_EX_word_en,
        input  i_EX_r31_ctrl, i_EX_signed, i_EX_branch_addr, i_EX_alu_result,
        input  i_EX_data_b, i_EX_selected_reg, i_EX_pc, i_du_req, i_du_addr,
        output o_MEM_pc_src, o_MEM_branch_addr, o_WB_reg_write, o_WB_selected_reg,
        output o_WB_write_data, o_misaligned, o_du_ack, o_du_data
    );

    modport master (
        output i_enable, i_flush,
        output i_EX_reg_write, i_EX_mem_to_reg, i_EX_mem_read, i_EX_mem_write,
        output i_EX_branch, i_EX_zero, i_EX_byte_en, i_EX_halfword_en, i_EX_word_en,
        output i_EX_r31_ctrl, i_EX_signed, i_EX_branch_addr, i_EX_alu_result,
        output i_EX_data_b, i_EX_selected_reg, i_EX_pc, i_du_req, i_du_addr,
        input  o_MEM_pc_src, o_MEM_branch_addr, o_WB_reg_write, o_WB_selected_reg,
        input  o_WB_write_data, o_misaligned, o_du_ack, o_du_data
    );
endinterface

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register, byte-lane data RAM, branch resolve, MEM/WB register; WB valid one edge after capture.
// i_enable=0 stalls everything; the debug port borrows the RAM read port only while the pipeline is stalled.
module mem_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_PC   = 32,
    parameter int NB_REG  = 5,
    parameter int NB_ADDR = 8
) (
    input logic        i_clock,
    input logic        i_reset,
    mem_stage_if.slave bus
);
    typedef struct packed {
        logic               reg_write;
        logic               mem_to_reg;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic               zero;
        logic               byte_en;
        logic               half_en;
        logic               word_en;
        logic               r31;
        logic               sgn;
        logic [NB_PC-1:0]   branch_addr;
        logic [NB_DATA-1:0] alu_result;
        logic [NB_DATA-1:0] data_b;
        logic [NB_REG-1:0]  sel_reg;
        logic [NB_PC-1:0]   pc;
    } exmem_t;

    typedef enum logic [1:0] {DU_IDLE = 2'd0, DU_READ = 2'd1, DU_ACK = 2'd2} du_state_e;

    exmem_t             ex_in, exmem_d, exmem_q;
    logic [NB_DATA-1:0] mem_q [2**NB_ADDR];
    logic [NB_ADDR-1:0] ex_word, rd_addr;
    logic [NB_DATA-1:0] rd_word;
    logic [1:0]         lane;
    logic               sz_word, sz_half, sz_byte, mis, store_en;
    logic [4:0]         st_shamt, ld_shamt;
    logic [NB_DATA-1:0] st_mask, st_data, st_merged, ld_shift, ld_data;

    logic               wb_reg_write_d, wb_reg_write_q;
    logic [NB_REG-1:0]  wb_sel_d, wb_sel_q;
    logic [NB_DATA-1:0] wb_data_d, wb_data_q;
    logic               mis_d, mis_q;
    du_state_e          du_state_d, du_state_q;
    logic [NB_DATA-1:0] du_data_d, du_data_q;

    always_comb begin
        ex_in             = '0;
        ex_in.reg_write   = bus.i_EX_reg_write;
        ex_in.mem_to_reg  = bus.i_EX_mem_to_reg;
        ex_in.mem_read    = bus.i_EX_mem_read;
        ex_in.mem_write   = bus.i_EX_mem_write;
        ex_in.branch      = bus.i_EX_branch;
        ex_in.zero        = bus.i_EX_zero;
        ex_in.byte_en     = bus.i_EX_byte_en;
        ex_in.half_en     = bus.i_EX_halfword_en;
        ex_in.word_en     = bus.i_EX_word_en;
        ex_in.r31         = bus.i_EX_r31_ctrl;
        ex_in.sgn         = bus.i_EX_signed;
        ex_in.branch_addr = bus.i_EX_branch_addr;
        ex_in.alu_result  = bus.i_EX_alu_result;
        ex_in.data_b      = bus.i_EX_data_b;
        ex_in.sel_reg     = bus.i_EX_selected_reg;
        ex_in.pc          = bus.i_EX_pc;
    end

    // Flush kills the side-effecting controls even while stalled; data fields follow i_enable.
    always_comb begin
        exmem_d = exmem_q;
        if (bus.i_enable) begin
            exmem_d = ex_in;
        end
        if (bus.i_flush) begin
            exmem_d.reg_write = 1'b0;
            exmem_d.mem_read  = 1'b0;
            exmem_d.mem_write = 1'b0;
            exmem_d.branch    = 1'b0;
            exmem_d.r31       = 1'b0;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            exmem_q <= '0;
        end else begin
            exmem_q <= exmem_d;
        end
    end

    assign ex_word = exmem_q.alu_result[NB_ADDR+1:2];
    assign lane    = exmem_q.alu_result[1:0];

    // No size enable at all is treated as a word access.
    assign sz_word = exmem_q.word_en | ~(exmem_q.half_en | exmem_q.byte_en);
    assign sz_half = ~sz_word & exmem_q.half_en;
    assign sz_byte = ~sz_word & ~sz_half;
    assign mis     = (sz_half & lane[0]) | (sz_word & (lane != 2'b00));

    assign rd_addr = bus.i_enable ? ex_word : bus.i_du_addr;
    assign rd_word = mem_q[rd_addr];

    assign st_shamt = sz_half ? {lane[1], 4'b0000} : {lane, 3'b000};
    always_comb begin
        st_mask = '1;
        st_data = exmem_q.data_b;
        if (sz_half) begin
            st_mask = NB_DATA'(16'hFFFF) << st_shamt;
            st_data = NB_DATA'(exmem_q.data_b[15:0]) << st_shamt;
        end else if (sz_byte) begin
            st_mask = NB_DATA'(8'hFF) << st_shamt;
            st_data = NB_DATA'(exmem_q.data_b[7:0]) << st_shamt;
        end
    end
    assign st_merged = (rd_word & ~st_mask) | (st_data & st_mask);
    assign store_en  = bus.i_enable & exmem_q.mem_write & ~mis;

    always_ff @(posedge i_clock) begin
        if (store_en) begin
            mem_q[ex_word] <= st_merged;
        end
    end

    assign ld_shamt = st_shamt;
    assign ld_shift = rd_word >> ld_shamt;
    always_comb begin
        ld_data = rd_word;
        if (mis) begin
            ld_data = '0;
        end else if (sz_half) begin
            ld_data = {{(NB_DATA-16){exmem_q.sgn & ld_shift[15]}}, ld_shift[15:0]};
        end else if (sz_byte) begin
            ld_data = {{(NB_DATA-8){exmem_q.sgn & ld_shift[7]}}, ld_shift[7:0]};
        end
    end

    always_comb begin
        wb_reg_write_d = wb_reg_write_q;
        wb_sel_d       = wb_sel_q;
        wb_data_d      = wb_data_q;
        mis_d          = 1'b0;
        if (bus.i_enable) begin
            wb_reg_write_d = exmem_q.reg_write;
            wb_sel_d       = exmem_q.r31 ? NB_REG'(31) : exmem_q.sel_reg;
            if (exmem_q.mem_to_reg) begin
                wb_data_d = ld_data;
            end else if (exmem_q.r31) begin
                wb_data_d = NB_DATA'(exmem_q.pc);
            end else begin
                wb_data_d = exmem_q.alu_result;
            end
            mis_d = (exmem_q.mem_read | exmem_q.mem_write) & mis;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wb_reg_write_q <= 1'b0;
            wb_sel_q       <= '0;
            wb_data_q      <= '0;
            mis_q          <= 1'b0;
        end else begin
            wb_reg_write_q <= wb_reg_write_d;
            wb_sel_q       <= wb_sel_d;
            wb_data_q      <= wb_data_d;
            mis_q          <= mis_d;
        end
    end

    // Any cycle with i_enable=1 hands the read port back to the pipeline and drops the debug transfer.
    always_comb begin
        du_state_d = du_state_q;
        du_data_d  = du_data_q;
        case (du_state_q)
            DU_IDLE: begin
                if (bus.i_du_req && !bus.i_enable) begin
                    du_state_d = DU_READ;
                end
            end
            DU_READ: begin
                if (bus.i_enable) begin
                    du_state_d = DU_IDLE;
                end else begin
                    du_state_d = DU_ACK;
                    du_data_d  = rd_word;
                end
            end
            DU_ACK: begin
                if (bus.i_enable || !bus.i_du_req) begin
                    du_state_d = DU_IDLE;
                end
            end
            default: du_state_d = DU_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            du_state_q <= DU_IDLE;
            du_data_q  <= '0;
        end else begin
            du_state_q <= du_state_d;
            du_data_q  <= du_data_d;
        end
    end

    assign bus.o_MEM_pc_src      = exmem_q.branch & exmem_q.zero;
    assign bus.o_MEM_branch_addr = exmem_q.branch_addr;
    assign bus.o_WB_reg_write    = wb_reg_write_q;
    assign bus.o_WB_selected_reg = wb_sel_q;
    assign bus.o_WB_write_data   = wb_data_q;
    assign bus.o_misaligned      = mis_q;
    assign bus.o_du_ack          = (du_state_q == DU_ACK);
    assign bus.o_du_data         = du_data_q;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: scoreboarded loads/stores/links plus directed branch, flush, stall, debug and reset checks.
module tb_mem_stage;
    typedef struct packed {
        logic        regw, m2r, mrd, mwr, br, zero, b, h, w, r31, sgn;
        logic [31:0] baddr, alu, datab;
        logic [4:0]  sel;
        logic [31:0] pc;
    } ex_op_t;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    logic   drv_vld = 1'b0;
    bit     ex_has_op = 1'b0;
    bit     fire;
    exp_t   exp_q[$];
    exp_t   mon_e;
    int     n_chk = 0;
    int     n_fail = 0;
    ex_op_t nop = '0;

    mem_stage_if #(.NB_DATA(32), .NB_PC(32), .NB_REG(5), .NB_ADDR(8)) bus ();

    mem_stage #(.NB_DATA(32), .NB_PC(32), .NB_REG(5), .NB_ADDR(8)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic put(input ex_op_t o);
        bus.i_EX_reg_write    = o.regw;
        bus.i_EX_mem_to_reg   = o.m2r;
        bus.i_EX_mem_read     = o.mrd;
        bus.i_EX_mem_write    = o.mwr;
        bus.i_EX_branch       = o.br;
        bus.i_EX_zero         = o.zero;
        bus.i_EX_byte_en      = o.b;
        bus.i_EX_halfword_en  = o.h;
        bus.i_EX_word_en      = o.w;
        bus.i_EX_r31_ctrl     = o.r31;
        bus.i_EX_signed       = o.sgn;
        bus.i_EX_branch_addr  = o.baddr;
        bus.i_EX_alu_result   = o.alu;
        bus.i_EX_data_b       = o.datab;
        bus.i_EX_selected_reg = o.sel;
        bus.i_EX_pc           = o.pc;
    endtask

    function automatic ex_op_t st(input int sz, input logic [31:0] a, input logic [31:0] d);
        ex_op_t o = '0;
        o.mwr = 1'b1; o.b = (sz == 0); o.h = (sz == 1); o.w = (sz == 2);
        o.alu = a; o.datab = d;
        return o;
    endfunction

    function automatic ex_op_t ld(input int sz, input bit s, input logic [31:0] a, input logic [4:0] r);
        ex_op_t o = '0;
        o.regw = 1'b1; o.m2r = 1'b1; o.mrd = 1'b1; o.sgn = s;
        o.b = (sz == 0); o.h = (sz == 1); o.w = (sz == 2);
        o.alu = a; o.sel = r;
        return o;
    endfunction

    // One EX bundle per falling edge; scored ops queue their write-back expectation.
    task automatic drive(input ex_op_t o, input bit scored, input logic [4:0] xr, input logic [31:0] xd);
        exp_t e;
        @(negedge clk);
        put(o);
        bus.i_enable = 1'b1;
        bus.i_flush  = 1'b0;
        drv_vld      = scored;
        if (scored) begin
            e.r = xr;
            e.d = xd;
            exp_q.push_back(e);
        end
    endtask

    task automatic bubble();
        drive(nop, 1'b0, 5'd0, 32'd0);
    endtask

    // A scored op reaches WB on the enabled edge after the one that captured it.
    always @(posedge clk) begin
        fire = ex_has_op && bus.i_enable && !rst;
        if (bus.i_enable && !rst) ex_has_op = drv_vld;
        if (fire) begin
            #1;
            check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("wb_we", 32'(bus.o_WB_reg_write), 32'd1);
                check("wb_reg", 32'(bus.o_WB_selected_reg), 32'(mon_e.r));
                check("wb_data", bus.o_WB_write_data, mon_e.d);
            end
        end
    end

    always @(posedge rst) ex_has_op = 1'b0;

    task automatic check_all_zero(input string pfx);
        check({pfx, "_pc_src"}, 32'(bus.o_MEM_pc_src), 32'd0);
        check({pfx, "_baddr"}, bus.o_MEM_branch_addr, 32'd0);
        check({pfx, "_wb_we"}, 32'(bus.o_WB_reg_write), 32'd0);
        check({pfx, "_wb_reg"}, 32'(bus.o_WB_selected_reg), 32'd0);
        check({pfx, "_wb_data"}, bus.o_WB_write_data, 32'd0);
        check({pfx, "_mis"}, 32'(bus.o_misaligned), 32'd0);
        check({pfx, "_ack"}, 32'(bus.o_du_ack), 32'd0);
        check({pfx, "_du_data"}, bus.o_du_data, 32'd0);
    endtask

    initial begin
        ex_op_t o;
        put(nop);
        bus.i_enable = 1'b0;
        bus.i_flush  = 1'b0;
        bus.i_du_req = 1'b0;
        bus.i_du_addr = '0;
        #1 rst = 1'b1;
        #2 check_all_zero("rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Word store, then signed byte and unsigned half loads from it.
        drive(st(2, 32'h10, 32'hDEADBEEF), 1'b0, 5'd0, 32'd0);
        drive(ld(0, 1'b1, 32'h13, 5'd3), 1'b1, 5'd3, 32'hFFFFFFDE);
        drive(ld(1, 1'b0, 32'h12, 5'd4), 1'b1, 5'd4, 32'h0000DEAD);

        // Lane merging: byte and upper-half stores into a zeroed word.
        drive(st(2, 32'h20, 32'h0), 1'b0, 5'd0, 32'd0);
        drive(st(0, 32'h21, 32'hAAAAAA55), 1'b0, 5'd0, 32'd0);
        drive(st(1, 32'h22, 32'hFFFF8001), 1'b0, 5'd0, 32'd0);
        drive(ld(2, 1'b0, 32'h20, 5'd5), 1'b1, 5'd5, 32'h80015500);
        drive(ld(1, 1'b1, 32'h22, 5'd6), 1'b1, 5'd6, 32'hFFFF8001);
        drive(ld(0, 1'b0, 32'h21, 5'd7), 1'b1, 5'd7, 32'h00000055);
        drive(ld(0, 1'b1, 32'h23, 5'd8), 1'b1, 5'd8, 32'hFFFFFF80);
        drive(ld(1, 1'b1, 32'h20, 5'd9), 1'b1, 5'd9, 32'h00005500);
        // Upper address bits wrap onto the same word.
        drive(ld(2, 1'b0, 32'h00000410, 5'd10), 1'b1, 5'd10, 32'hDEADBEEF);
        bubble();

        // Misaligned half store is dropped and pulses o_misaligned for one cycle.
        drive(st(1, 32'h11, 32'h00001234), 1'b0, 5'd0, 32'd0);
        bubble();
        @(negedge clk);
        check("mis_pulse", 32'(bus.o_misaligned), 32'd1);
        @(negedge clk);
        check("mis_drop", 32'(bus.o_misaligned), 32'd0);
        drive(ld(2, 1'b0, 32'h10, 5'd11), 1'b1, 5'd11, 32'hDEADBEEF);
        drive(ld(2, 1'b0, 32'h12, 5'd12), 1'b1, 5'd12, 32'h00000000);
        bubble();

        // Branch resolves for exactly one cycle; flush overrides a stall.
        o = '0; o.br = 1'b1; o.zero = 1'b1; o.baddr = 32'h80;
        drive(o, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("br_taken", 32'(bus.o_MEM_pc_src), 32'd1);
        check("br_addr", bus.o_MEM_branch_addr, 32'h80);
        put(nop);
        @(negedge clk);
        check("br_one_cycle", 32'(bus.o_MEM_pc_src), 32'd0);
        drive(o, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("br_taken2", 32'(bus.o_MEM_pc_src), 32'd1);
        bus.i_enable = 1'b0;
        bus.i_flush  = 1'b1;
        @(negedge clk);
        check("br_flushed", 32'(bus.o_MEM_pc_src), 32'd0);
        bus.i_flush = 1'b0;
        bubble();

        // Link to r31, then stall three cycles with a different op waiting on EX.
        o = '0; o.regw = 1'b1; o.r31 = 1'b1; o.pc = 32'h40; o.alu = 32'h999; o.sel = 5'd5;
        drive(o, 1'b1, 5'd31, 32'h40);
        bubble();
        @(negedge clk);
        put(ld(2, 1'b0, 32'h10, 5'd2));
        bus.i_enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_wb_we", 32'(bus.o_WB_reg_write), 32'd1);
            check("stall_wb_reg", 32'(bus.o_WB_selected_reg), 32'd31);
            check("stall_wb_data", bus.o_WB_write_data, 32'h40);
        end
        bubble();
        bubble();

        // Debug read while halted, then an abort by re-enabling mid-READ.
        @(negedge clk);
        put(nop);
        bus.i_enable  = 1'b0;
        bus.i_du_req  = 1'b1;
        bus.i_du_addr = 8'd4;
        @(negedge clk);
        check("du_ack_early", 32'(bus.o_du_ack), 32'd0);
        @(negedge clk);
        check("du_ack", 32'(bus.o_du_ack), 32'd1);
        check("du_data", bus.o_du_data, 32'hDEADBEEF);
        @(negedge clk);
        check("du_ack_hold", 32'(bus.o_du_ack), 32'd1);
        bus.i_du_req = 1'b0;
        @(negedge clk);
        check("du_ack_drop", 32'(bus.o_du_ack), 32'd0);
        bus.i_du_req = 1'b1;
        @(negedge clk);
        bus.i_enable = 1'b1;
        @(negedge clk);
        check("du_abort", 32'(bus.o_du_ack), 32'd0);
        @(negedge clk);
        check("du_abort_idle", 32'(bus.o_du_ack), 32'd0);
        bus.i_du_req = 1'b0;

        // Asynchronous reset in the middle of a load, then the load again.
        drive(ld(2, 1'b0, 32'h10, 5'd7), 1'b1, 5'd7, 32'hDEADBEEF);
        drive(ld(2, 1'b0, 32'h10, 5'd8), 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        put(nop);
        #1 check_all_zero("arst");
        @(negedge clk);
        rst = 1'b0;
        drive(ld(2, 1'b0, 32'h10, 5'd8), 1'b1, 5'd8, 32'hDEADBEEF);
        bubble();
        repeat (2) @(negedge clk);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
